pipeline_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards and branch flushes.
- Runs a req/ack handshake with a variable-latency data memory, freezing the pipeline until the access completes.
- Drives the write-enable, bubble and flush controls of every pipeline register, plus a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_stall_ctrl_hazard_detect.sv | 25 ++
 rtl/pipeline_stall_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_t    : memory handshake FSM state (IDLE / REQ / DONE)
//   REG_ADDR_W : register-file address width
//   REG_ZERO   : hard-wired zero register, never a real hazard source
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector.
//   i_idex_memread : load sitting in EX
//   i_idex_rt      : destination of that load
//   i_ifid_rs/rt   : source registers of the instruction in ID
//   o_load_use     : ID instruction needs the load result next cycle
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                  i_idex_memread,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    output logic                  o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_idex_rt == i_ifid_rs);
    assign w_rt_hit = (i_idex_rt == i_ifid_rt);

    // Writes to the zero register are discarded, so they never create a hazard.
    assign o_load_use = i_idex_memread & (i_idex_rt != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Combines the data-memory req/ack handshake, load-use detection and branch
// flush into the per-register write/bubble/flush controls, and counts stalls.
// Optional build macro: MEM_TIMEOUT_EN adds a REQ watchdog and mem_err_o.
// Ports:
//   clk_i, rst_i (async, active-high)
//   IDEX_MemRead_i, IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i : load-use inputs
//   branch_taken_i                   : taken branch resolved in ID
//   EXMEM_MemRead_i/MemWrite_i       : memory op in MEM
//   dmem_ack_i / dmem_req_o          : data memory handshake
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
//   exmem_hold_o, memwb_bubble_o     : pipeline register controls
//   stall_cnt_o                      : saturating stalled-cycle count
//   mem_err_o                        : sticky memory timeout flag
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RegRt_i,
    input  logic [REG_ADDR_W-1:0] IFID_RegRs_i,
    input  logic [REG_ADDR_W-1:0] IFID_RegRt_i,
    input  logic                  branch_taken_i,
    input  logic                  EXMEM_MemRead_i,
    input  logic                  EXMEM_MemWrite_i,
    input  logic                  dmem_ack_i,
    output logic                  dmem_req_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  exmem_hold_o,
    output logic                  memwb_bubble_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  mem_err_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           r_state;
    logic             r_req;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_mem_op;
    logic             w_mem_stall;
    logic             w_load_use;
    logic             w_pc_write;

    assign w_mem_op = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    // The detect cycle in IDLE already freezes, so the minimum freeze is two
    // cycles; DONE is the single release cycle in which MEM/WB captures data.
    assign w_mem_stall = (r_state == REQ) | ((r_state == IDLE) & w_mem_op);

    hazard_detect u_hazard (
        .i_idex_memread (IDEX_MemRead_i),
        .i_idex_rt      (IDEX_RegRt_i),
        .i_ifid_rs      (IFID_RegRs_i),
        .i_ifid_rt      (IFID_RegRt_i),
        .o_load_use     (w_load_use)
    );

    // Priority: mem_stall > load_use > flush. A branch blocked by load_use
    // is simply resolved again on the next cycle.
    assign w_pc_write     = ~(w_mem_stall | w_load_use);
    assign pc_write_o     = w_pc_write;
    assign ifid_write_o   = w_pc_write;
    assign idex_bubble_o  = w_load_use & ~w_mem_stall;
    assign ifid_flush_o   = branch_taken_i & ~w_mem_stall & ~w_load_use;
    assign exmem_hold_o   = w_mem_stall;
    assign memwb_bubble_o = w_mem_stall;
    assign dmem_req_o     = r_req;
    assign stall_cnt_o    = r_stall_cnt;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] r_wait;
    logic              r_err;

    assign mem_err_o = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_wait  <= '0;
                    end
                end
                REQ: begin
                    // An ack on the timeout cycle wins: it is a success.
                    if (dmem_ack_i) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                    end else if (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_wait  <= r_wait + 1'b1;
                    end else begin
                        r_wait  <= r_wait + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
`else
    assign mem_err_o = 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl. The stimulus process applies one
// directed input vector per cycle shortly after the rising edge and queues
// the hand-computed outputs for that cycle; a monitor on the falling edge
// pops and compares. The counter is narrowed to 4 bits so saturation is
// reachable, and the watchdog is shortened to 4 cycles.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    typedef struct packed {
        logic       idex_rd;
        logic [4:0] idex_rt;
        logic [4:0] ifid_rs;
        logic [4:0] ifid_rt;
        logic       br;
        logic       exm_rd;
        logic       exm_wr;
        logic       ack;
        logic       rst;
    } in_t;

    typedef struct packed {
        logic             pcw;
        logic             ifw;
        logic             flush;
        logic             bub;
        logic             hold;
        logic             mwb;
        logic             req;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } exp_t;

    typedef struct {
        int   id;
        exp_t e;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             idex_rd = 1'b0, br = 1'b0, exm_rd = 1'b0, exm_wr = 1'b0, ack = 1'b0;
    logic [4:0]       idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
    logic             dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble;
    logic             exmem_hold, memwb_bubble, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    sb_t sb_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  vec_id = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .IDEX_MemRead_i   (idex_rd),
        .IDEX_RegRt_i     (idex_rt),
        .IFID_RegRs_i     (ifid_rs),
        .IFID_RegRt_i     (ifid_rt),
        .branch_taken_i   (br),
        .EXMEM_MemRead_i  (exm_rd),
        .EXMEM_MemWrite_i (exm_wr),
        .dmem_ack_i       (ack),
        .dmem_req_o       (dmem_req),
        .pc_write_o       (pc_write),
        .ifid_write_o     (ifid_write),
        .ifid_flush_o     (ifid_flush),
        .idex_bubble_o    (idex_bubble),
        .exmem_hold_o     (exmem_hold),
        .memwb_bubble_o   (memwb_bubble),
        .stall_cnt_o      (stall_cnt),
        .mem_err_o        (mem_err)
    );

    function automatic in_t I(input logic ird, input logic [4:0] irt, input logic [4:0] rs,
                              input logic [4:0] rt, input logic b, input logic mr,
                              input logic mw, input logic a, input logic r);
        I = '{ird, irt, rs, rt, b, mr, mw, a, r};
    endfunction

    function automatic exp_t E(input logic p, input logic f, input logic fl, input logic bb,
                               input logic h, input logic m, input logic q, input int c,
                               input logic er);
        E = '{p, f, fl, bb, h, m, q, CNT_W'(c), er};
    endfunction

    // Apply one cycle of inputs (after the rising edge) and queue its expectation.
    task automatic step(input in_t i, input exp_t e);
        sb_t s;
        @(posedge clk);
        #1;
        idex_rd = i.idex_rd; idex_rt = i.idex_rt; ifid_rs = i.ifid_rs; ifid_rt = i.ifid_rt;
        br = i.br; exm_rd = i.exm_rd; exm_wr = i.exm_wr; ack = i.ack; rst = i.rst;
        vec_id++;
        s.id = vec_id;
        s.e  = e;
        sb_q.push_back(s);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t  s;
            exp_t a;
            s = sb_q.pop_front();
            a = '{pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
                  memwb_bubble, dmem_req, stall_cnt, mem_err};
            n_cmp++;
            if (a !== s.e) begin
                n_fail++;
                $display("FAIL vec%0d: got pcw=%b ifw=%b fl=%b bub=%b hold=%b mwb=%b req=%b cnt=%0d err=%b, want pcw=%b ifw=%b fl=%b bub=%b hold=%b mwb=%b req=%b cnt=%0d err=%b",
                         s.id, a.pcw, a.ifw, a.flush, a.bub, a.hold, a.mwb, a.req, a.cnt, a.err,
                         s.e.pcw, s.e.ifw, s.e.flush, s.e.bub, s.e.hold, s.e.mwb, s.e.req, s.e.cnt, s.e.err);
            end
        end
    end

    localparam in_t Q = '0;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Quiescent after reset
        step(Q, E(1,1,0,0,0,0,0,0,0));
        step(Q, E(1,1,0,0,0,0,0,0,0));

        // Load in MEM, ack in the third REQ cycle: 4 frozen cycles then DONE
        step(I(0,0,0,0,0,1,0,0,0), E(0,0,0,0,1,1,0,0,0));
        step(I(0,0,0,0,0,1,0,0,0), E(0,0,0,0,1,1,1,1,0));
        step(I(0,0,0,0,0,1,0,0,0), E(0,0,0,0,1,1,1,2,0));
        step(I(0,0,0,0,0,1,0,1,0), E(0,0,0,0,1,1,1,3,0));
        step(Q,                    E(1,1,0,0,0,0,0,4,0));
        step(Q,                    E(1,1,0,0,0,0,0,4,0));

        // Load-use via rs, then dest = $zero (no hazard), then via rt
        step(I(1,8,8,0,0,0,0,0,0), E(0,0,0,1,0,0,0,4,0));
        step(I(1,0,0,0,0,0,0,0,0), E(1,1,0,0,0,0,0,5,0));
        step(I(1,9,3,9,0,0,0,0,0), E(0,0,0,1,0,0,0,5,0));

        // Branch with load-use: no flush; hazard gone next cycle: flush
        step(I(1,8,8,0,1,0,0,0,0), E(0,0,0,1,0,0,0,6,0));
        step(I(0,0,0,0,1,0,0,0,0), E(1,1,1,0,0,0,0,7,0));

        // Store with load-use and branch all at once: mem_stall dominates;
        // immediate ack gives the minimum 2-cycle freeze
        step(I(1,8,8,0,1,0,1,0,0), E(0,0,0,0,1,1,0,7,0));
        step(I(0,0,0,0,0,0,1,1,0), E(0,0,0,0,1,1,1,8,0));
        step(Q,                    E(1,1,0,0,0,0,0,9,0));

        // Ack while IDLE is ignored
        step(I(0,0,0,0,0,0,0,1,0), E(1,1,0,0,0,0,0,9,0));
        step(Q,                    E(1,1,0,0,0,0,0,9,0));

`ifdef MEM_TIMEOUT_EN
        // No ack: watchdog fires after 4 REQ cycles, releases, error sticks
        step(I(0,0,0,0,0,1,0,0,0), E(0,0,0,0,1,1,0,9,0));
        for (int k = 0; k < TMO; k++)
            step(Q, E(0,0,0,0,1,1,1,10+k,0));
        step(Q, E(1,1,0,0,0,0,0,14,1));
        step(Q, E(1,1,0,0,0,0,0,14,1));
        step(Q, E(1,1,0,0,0,0,0,14,1));
`else
        // No watchdog: REQ waits past 4 cycles; counter saturates at 15
        step(I(0,0,0,0,0,1,0,0,0), E(0,0,0,0,1,1,0,9,0));
        for (int k = 0; k < 5; k++)
            step(Q, E(0,0,0,0,1,1,1,10+k,0));
        step(I(0,0,0,0,0,0,0,1,0), E(0,0,0,0,1,1,1,15,0));
        step(Q,                    E(1,1,0,0,0,0,0,15,0));
`endif

        // Reset mid-REQ: request drops immediately, late ack ignored
        step(I(0,0,0,0,0,1,0,0,0), E(0,0,0,0,1,1,0,15,0));
        step(Q,                    E(0,0,0,0,1,1,1,15,0));
        step(I(0,0,0,0,0,0,0,0,1), E(1,1,0,0,0,0,0,0,0));
        step(I(0,0,0,0,0,0,0,1,0), E(1,1,0,0,0,0,0,0,0));
        step(Q,                    E(1,1,0,0,0,0,0,0,0));

        // Sustained load-use: counter saturates at all-ones
        for (int k = 0; k < 18; k++)
            step(I(1,5,5,0,0,0,0,0,0), E(0,0,0,1,0,0,0,(k > 15) ? 15 : k,0));
        step(Q, E(1,1,0,0,0,0,0,15,0));

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
